// File: rtl/vend_pkg.sv
// Shared types for the vending transaction engine: response status codes,
// FSM state encoding and width helpers for the cost arithmetic.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_OK        = 3'd0,
        ST_BAD_ID    = 3'd1,
        ST_BAD_QTY   = 3'd2,
        ST_SOLD_OUT  = 3'd3,
        ST_NO_CREDIT = 3'd4
    } status_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_CHECK  = 3'd2,
        S_COMMIT = 3'd3,
        S_RESP   = 3'd4,
        S_TOPUP  = 3'd5
    } state_t;

    // cost = price * qty needs the sum of both operand widths
    function automatic int cost_width(input int price_w, input int qty_w);
        return price_w + qty_w;
    endfunction

    function automatic int max_width(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vend_table.sv
// Single-port table with synchronous read and one write port.
// Ports: clk, we/addr/wdata (write), rdata (registered read of addr).
module vend_table #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are not reset; they hold the preloaded image.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/vend_controller.sv
// Vending transaction engine: checks stock and credit for a
// (student, product, qty) request, debits both atomically, returns a status.
// Ports: clk, reset (sync, active-low), req_* (valid/ready request),
//   rsp_* (valid/ready response with status and remaining credit).
// Optional: define VEND_TOPUP_EN to add the top_* credit top-up port.
module vend_controller
    import vend_pkg::*;
#(
    parameter int N_PRODUCTS = 16,
    parameter int N_STUDENTS = 16,
    parameter int PRICE_W    = 4,
    parameter int CREDIT_W   = 8,
    parameter int STOCK_W    = 4,
    parameter int QTY_W      = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [$clog2(N_STUDENTS)-1:0] req_student,
    input  logic [$clog2(N_PRODUCTS)-1:0] req_product,
    input  logic [QTY_W-1:0]              req_qty,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output status_t                       rsp_status,
    output logic [CREDIT_W-1:0]           rsp_credit
`ifdef VEND_TOPUP_EN
    ,
    input  logic                          top_valid,
    output logic                          top_ready,
    input  logic [$clog2(N_STUDENTS)-1:0] top_student,
    input  logic [CREDIT_W-1:0]           top_amount
`endif
);

    localparam int SID_W  = $clog2(N_STUDENTS);
    localparam int PID_W  = $clog2(N_PRODUCTS);
    localparam int COST_W = cost_width(PRICE_W, QTY_W);
    localparam int CMP_W  = max_width(CREDIT_W, COST_W);
    localparam int SQ_W   = max_width(STOCK_W, QTY_W);

    state_t state;

    logic [SID_W-1:0]    stu_q;
    logic [PID_W-1:0]    prod_q;
    logic [QTY_W-1:0]    qty_q;

    logic [PRICE_W-1:0]  price_rd;
    logic [STOCK_W-1:0]  stock_rd;
    logic [CREDIT_W-1:0] credit_rd;

    logic [SID_W-1:0]    credit_addr;
    logic                credit_we;
    logic [CREDIT_W-1:0] credit_wdata;
    logic                commit_we;

    logic [COST_W-1:0]   cost;
    logic [CREDIT_W-1:0] credit_new;
    logic [STOCK_W-1:0]  stock_new;

    logic [31:0]         stu_ext;
    logic [31:0]         prod_ext;
    logic                stu_ok;
    logic                prod_ok;
    status_t             chk_status;

    // Index checks in 32 bits so non-power-of-two depths are caught.
    assign stu_ext  = 32'(stu_q);
    assign prod_ext = 32'(prod_q);
    assign stu_ok   = stu_ext < 32'(N_STUDENTS);
    assign prod_ok  = prod_ext < 32'(N_PRODUCTS);

    assign cost       = COST_W'(price_rd) * COST_W'(qty_q);
    assign credit_new = credit_rd - CREDIT_W'(cost);
    assign stock_new  = stock_rd - STOCK_W'(qty_q);

    // A write in flight is dropped when reset is sampled on its edge.
    assign commit_we = (state == S_COMMIT) && reset;

    always_comb begin
        chk_status = ST_OK;
        if (!prod_ok || price_rd == '0) begin
            chk_status = ST_BAD_ID;
        end else if (!stu_ok) begin
            chk_status = ST_BAD_ID;
        end else if (qty_q == '0) begin
            chk_status = ST_BAD_QTY;
        end else if (SQ_W'(stock_rd) < SQ_W'(qty_q)) begin
            chk_status = ST_SOLD_OUT;
        end else if (CMP_W'(credit_rd) < CMP_W'(cost)) begin
            chk_status = ST_NO_CREDIT;
        end
    end

`ifdef VEND_TOPUP_EN
    logic [CREDIT_W-1:0] amt_q;
    logic                top_ok_q;
    logic [CREDIT_W:0]   top_sum;
    logic                top_we;
    logic [31:0]         top_ext;

    assign top_ext   = 32'(top_student);
    assign top_ready = req_ready && !req_valid;
    assign top_sum   = {1'b0, credit_rd} + {1'b0, amt_q};
    assign top_we    = (state == S_TOPUP) && reset && top_ok_q;

    // In IDLE the credit port looks at top_student so the old value
    // is ready in S_TOPUP for the saturating add.
    assign credit_addr  = (state == S_IDLE) ? top_student : stu_q;
    assign credit_we    = commit_we || top_we;
    assign credit_wdata = top_we ?
        (top_sum[CREDIT_W] ? '1 : top_sum[CREDIT_W-1:0]) : credit_new;
`else
    assign credit_addr  = stu_q;
    assign credit_we    = commit_we;
    assign credit_wdata = credit_new;
`endif

    vend_table #(.DEPTH(N_PRODUCTS), .WIDTH(PRICE_W)) u_price (
        .clk   (clk),
        .we    (1'b0),
        .addr  (prod_q),
        .wdata ('0),
        .rdata (price_rd)
    );

    vend_table #(.DEPTH(N_PRODUCTS), .WIDTH(STOCK_W)) u_stock (
        .clk   (clk),
        .we    (commit_we),
        .addr  (prod_q),
        .wdata (stock_new),
        .rdata (stock_rd)
    );

    vend_table #(.DEPTH(N_STUDENTS), .WIDTH(CREDIT_W)) u_credit (
        .clk   (clk),
        .we    (credit_we),
        .addr  (credit_addr),
        .wdata (credit_wdata),
        .rdata (credit_rd)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_status <= ST_OK;
            rsp_credit <= '0;
            stu_q      <= '0;
            prod_q     <= '0;
            qty_q      <= '0;
`ifdef VEND_TOPUP_EN
            amt_q      <= '0;
            top_ok_q   <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        stu_q     <= req_student;
                        prod_q    <= req_product;
                        qty_q     <= req_qty;
                        req_ready <= 1'b0;
                        state     <= S_READ;
                    end
`ifdef VEND_TOPUP_EN
                    else if (top_valid && top_ready) begin
                        stu_q     <= top_student;
                        amt_q     <= top_amount;
                        top_ok_q  <= top_ext < 32'(N_STUDENTS);
                        req_ready <= 1'b0;
                        state     <= S_TOPUP;
                    end
`endif
                end
                S_READ: begin
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (chk_status == ST_OK) begin
                        state <= S_COMMIT;
                    end else begin
                        rsp_status <= chk_status;
                        rsp_credit <= stu_ok ? credit_rd : '0;
                        rsp_valid  <= 1'b1;
                        state      <= S_RESP;
                    end
                end
                S_COMMIT: begin
                    rsp_status <= ST_OK;
                    rsp_credit <= credit_new;
                    rsp_valid  <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_TOPUP: begin
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed cases plus random
// requests against a plain-arithmetic model of the vending rules.
module tb_vend_controller;
    import vend_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_student = '0;
    logic [3:0] req_product = '0;
    logic [1:0] req_qty = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    status_t    rsp_status;
    logic [7:0] rsp_credit;
`ifdef VEND_TOPUP_EN
    logic       top_valid = 1'b0;
    logic       top_ready;
    logic [3:0] top_student = '0;
    logic [7:0] top_amount = '0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    int m_price [16];
    int m_stock [16];
    int m_credit[16];

    always #5 clk = ~clk;

    vend_controller dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_student (req_student),
        .req_product (req_product),
        .req_qty     (req_qty),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_status  (rsp_status),
        .rsp_credit  (rsp_credit)
`ifdef VEND_TOPUP_EN
        ,
        .top_valid   (top_valid),
        .top_ready   (top_ready),
        .top_student (top_student),
        .top_amount  (top_amount)
`endif
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Vending rules in plain arithmetic; updates the model on success.
    task automatic model(input int s, input int p, input int q,
                         output int st, output int cr);
        if (p >= 16 || m_price[p] == 0) st = 1;
        else if (s >= 16) st = 1;
        else if (q == 0) st = 2;
        else if (m_stock[p] < q) st = 3;
        else if (m_credit[s] < m_price[p] * q) st = 4;
        else begin
            st = 0;
            m_stock[p]  -= q;
            m_credit[s] -= m_price[p] * q;
        end
        cr = (s < 16) ? m_credit[s] : 0;
    endtask

    task automatic do_req(input int s, input int p, input int q,
                          input int hold);
        int est, ecr, lat, w;
        model(s, p, q, est, ecr);
        @(negedge clk);
        req_valid   = 1'b1;
        req_student = 4'(s);
        req_product = 4'(p);
        req_qty     = 2'(q);
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("req_ready", int'(req_ready), 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("rsp_valid", int'(rsp_valid), 1);
        chk("latency", lat, (est == 0) ? 3 : 2);
        chk("status", int'(rsp_status), est);
        chk("credit", int'(rsp_credit), ecr);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", int'(rsp_valid), 1);
            chk("hold_status", int'(rsp_status), est);
            chk("hold_credit", int'(rsp_credit), ecr);
            chk("hold_req_ready", int'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk("rsp_drop", int'(rsp_valid), 0);
        chk("ready_again", int'(req_ready), 1);
    endtask

`ifdef VEND_TOPUP_EN
    task automatic do_top(input int s, input int amt);
        int w;
        if (s < 16) begin
            m_credit[s] += amt;
            if (m_credit[s] > 255) m_credit[s] = 255;
        end
        @(negedge clk);
        top_valid   = 1'b1;
        top_student = 4'(s);
        top_amount  = 8'(amt);
        w = 0;
        while (!top_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("top_ready", int'(top_ready), 1);
        @(posedge clk);
        #1 top_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("top_done_ready", int'(req_ready), 1);
    endtask
`endif

    task automatic cmp_tables();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("stock[%0d]", i), int'(dut.u_stock.mem[i]), m_stock[i]);
            chk($sformatf("credit[%0d]", i), int'(dut.u_credit.mem[i]), m_credit[i]);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_price[i]  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
            m_stock[i]  = int'($urandom_range(0, 15));
            m_credit[i] = int'($urandom_range(0, 255));
        end
        m_price[3] = 5;  m_stock[3] = 2;  m_credit[7] = 12;
        m_price[4] = 6;  m_stock[4] = 9;  m_credit[1] = 11;
        m_price[5] = 0;
        m_price[6] = 3;  m_stock[6] = 5;  m_credit[2] = 100;
        for (int i = 0; i < 16; i++) begin
            dut.u_price.mem[i]  = 4'(m_price[i]);
            dut.u_stock.mem[i]  = 4'(m_stock[i]);
            dut.u_credit.mem[i] = 8'(m_credit[i]);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_status", int'(rsp_status), 0);
        chk("rst_credit", int'(rsp_credit), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", int'(req_ready), 1);

        do_req(7, 3, 2, 1);
        chk("stock3_zero", int'(dut.u_stock.mem[3]), 0);
        do_req(7, 3, 1, 5);
        do_req(1, 4, 2, 0);
        do_req(0, 5, 1, 0);
        do_req(0, 4, 0, 2);
        cmp_tables();

        // Reset lands on the COMMIT edge: nothing may be written.
        @(negedge clk);
        req_valid   = 1'b1;
        req_student = 4'd2;
        req_product = 4'd6;
        req_qty     = 2'd1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("commit_no_rsp", int'(rsp_valid), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_rsp_valid", int'(rsp_valid), 0);
        chk("abort_req_ready", int'(req_ready), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ready_next", int'(req_ready), 1);
        chk("abort_rsp_idle", int'(rsp_valid), 0);
        chk("abort_stock6", int'(dut.u_stock.mem[6]), m_stock[6]);
        chk("abort_credit2", int'(dut.u_credit.mem[2]), m_credit[2]);
        do_req(2, 6, 1, 0);

`ifdef VEND_TOPUP_EN
        @(negedge clk);
        m_credit[2] = 250;
        dut.u_credit.mem[2] = 8'd250;
        do_top(2, 10);
        do_req(2, 4, 0, 0);
        chk("sat_credit2", int'(dut.u_credit.mem[2]), 255);
        @(negedge clk);
        top_valid   = 1'b1;
        top_student = 4'd3;
        top_amount  = 8'd50;
        req_valid   = 1'b1;
        req_student = 4'd0;
        req_product = 4'd4;
        req_qty     = 2'd0;
        #1;
        chk("tie_top_ready", int'(top_ready), 0);
        chk("tie_req_ready", int'(req_ready), 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        top_valid = 1'b0;
        chk("tie_req_taken", int'(req_ready), 0);
        while (!rsp_valid) begin
            @(posedge clk);
            #1;
        end
        chk("tie_status", int'(rsp_status), 2);
        chk("tie_credit", int'(rsp_credit), m_credit[0]);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
`endif

        for (int n = 0; n < 40; n++) begin
`ifdef VEND_TOPUP_EN
            if ($urandom_range(0, 3) == 0) begin
                do_top(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
            end
`endif
            do_req(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end
        cmp_tables();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
